// File: rtl/cpu_datapath.sv
// cpu_datapath: 32-bit single-bus CPU datapath with strobe-driven bus mux, combinational ALU and 64-bit Z.
// Define IN_PORT_EN to add the InPort_data input register behind InPortout.
module cpu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic clr,
    input  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic HIin, Loin, PCin, MDRin, MARin, IRin, Yin,
    input  logic ZHIin, ZLOin, Zin,
    input  logic HIout, Loout, PCout, MDRout, Yout, Cout, InPortout,
    input  logic ZHIout, ZHighSelect, ZLOout, ZLowSelect,
    input  logic MDRread,
    input  logic IncPC,
    input  logic [4:0] ALU_opcode,
    input  logic [WIDTH-1:0] Mdatain,
`ifdef IN_PORT_EN
    input  logic [WIDTH-1:0] InPort_data,
`endif
    output logic [WIDTH-1:0] R0, R1, R2, R3, R4, R5, R6, R7,
    output logic [WIDTH-1:0] R8, R9, R10, R11, R12, R13, R14, R15,
    output logic [WIDTH-1:0] HI, LO, Y, ZLO, ZHI,
    output logic [2*WIDTH-1:0] Z_register
);
    localparam int SW = $clog2(WIDTH);
    logic [WIDTH-1:0] r_q [16];
    logic [WIDTH-1:0] r_d [16];
    logic [15:0] r_in, r_out;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_q, ir_d;
    logic [WIDTH-1:0] mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
    logic [2*WIDTH-1:0] z_q, z_d, alu;
    logic [WIDTH-1:0] bus, c_ext, in_port;
    logic signed [WIDTH-1:0] a, b;
    logic [SW-1:0] n;
    logic [SW:0] nc;
    logic unused_bits;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign c_ext = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};

`ifdef IN_PORT_EN
    logic [WIDTH-1:0] in_port_q;
    always_ff @(posedge clk) begin
        in_port_q <= clr ? '0 : InPort_data;
    end
    assign in_port = in_port_q;
`else
    assign in_port = '0;
`endif

    // Later assignments win, so sources are applied from lowest to highest priority.
    always_comb begin
        bus = '0;
        if (Yout) bus = y_q;
        if (Cout) bus = c_ext;
        if (InPortout) bus = in_port;
        if (MDRout) bus = mdr_q;
        if (PCout) bus = pc_q;
        if (ZLOout | ZLowSelect) bus = z_q[WIDTH-1:0];
        if (ZHIout | ZHighSelect) bus = z_q[2*WIDTH-1:WIDTH];
        if (Loout) bus = lo_q;
        if (HIout) bus = hi_q;
        for (int i = 15; i >= 0; i--) if (r_out[i]) bus = r_q[i];
    end

    assign a  = y_q;
    assign b  = bus;
    assign n  = bus[SW-1:0];
    assign nc = (SW+1)'(WIDTH) - {1'b0, n};

    always_comb begin
        alu = '0;
        case (ALU_opcode)
            5'b00000: alu[WIDTH-1:0] = a + b;
            5'b00001: alu[WIDTH-1:0] = a - b;
            5'b00010: alu[WIDTH-1:0] = a & b;
            5'b00011: alu[WIDTH-1:0] = a | b;
            5'b00100: alu[WIDTH-1:0] = a >> n;
            5'b00101: alu[WIDTH-1:0] = a >>> n;
            5'b00110: alu[WIDTH-1:0] = a << n;
            5'b00111: alu[WIDTH-1:0] = (a >> n) | (a << nc);
            5'b01000: alu[WIDTH-1:0] = (a << n) | (a >> nc);
            5'b01001: alu[WIDTH-1:0] = -b;
            5'b01010: alu[WIDTH-1:0] = ~b;
            5'b01111: alu = (2*WIDTH)'(a) * (2*WIDTH)'(b);
            5'b10000: alu = (b == '0) ? {a, {WIDTH{1'b0}}} : {a % b, a / b};
            default:  alu = '0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 16; i++) r_d[i] = r_in[i] ? bus : r_q[i];
    end

    assign hi_d  = HIin ? bus : hi_q;
    assign lo_d  = Loin ? bus : lo_q;
    assign ir_d  = IRin ? bus : ir_q;
    assign mar_d = MARin ? bus : mar_q;
    assign y_d   = Yin ? bus : y_q;
    assign mdr_d = MDRin ? (MDRread ? Mdatain : bus) : mdr_q;
    assign pc_d  = PCin ? bus : IncPC ? pc_q + WIDTH'(1) : pc_q;
    assign z_d[2*WIDTH-1:WIDTH] = (Zin | ZHIin) ? alu[2*WIDTH-1:WIDTH] : z_q[2*WIDTH-1:WIDTH];
    assign z_d[WIDTH-1:0]       = (Zin | ZLOin) ? alu[WIDTH-1:0] : z_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            r_q   <= r_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

    // MAR feeds the external address bus, which this block does not model.
    assign unused_bits = ^{mar_q, ir_q[WIDTH-1:19]};

    assign {R15, R14, R13, R12, R11, R10, R9, R8} = {r_q[15], r_q[14], r_q[13], r_q[12], r_q[11], r_q[10], r_q[9], r_q[8]};
    assign {R7, R6, R5, R4, R3, R2, R1, R0} = {r_q[7], r_q[6], r_q[5], r_q[4], r_q[3], r_q[2], r_q[1], r_q[0]};
    assign HI = hi_q;
    assign LO = lo_q;
    assign Y  = y_q;
    assign ZLO = z_q[WIDTH-1:0];
    assign ZHI = z_q[2*WIDTH-1:WIDTH];
    assign Z_register = z_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed transfers with a queue-based scoreboard checked by a separate monitor.
module tb_cpu_datapath;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr;
    logic [15:0] rin, rout;
    logic HIin, Loin, PCin, MDRin, MARin, IRin, Yin, ZHIin, ZLOin, Zin;
    logic HIout, Loout, PCout, MDRout, Yout, Cout, InPortout;
    logic ZHIout, ZHighSelect, ZLOout, ZLowSelect, MDRread, IncPC;
    logic [4:0] op;
    logic [31:0] mdat;
    logic [31:0] r [16];
    logic [31:0] HI, LO, Y, ZLO, ZHI;
    logic [63:0] Z_register;

    cpu_datapath dut (
        .clk(clk), .clr(clr),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIin(HIin), .Loin(Loin), .PCin(PCin), .MDRin(MDRin), .MARin(MARin), .IRin(IRin), .Yin(Yin),
        .ZHIin(ZHIin), .ZLOin(ZLOin), .Zin(Zin),
        .HIout(HIout), .Loout(Loout), .PCout(PCout), .MDRout(MDRout), .Yout(Yout), .Cout(Cout),
        .InPortout(InPortout), .ZHIout(ZHIout), .ZHighSelect(ZHighSelect),
        .ZLOout(ZLOout), .ZLowSelect(ZLowSelect), .MDRread(MDRread), .IncPC(IncPC),
        .ALU_opcode(op), .Mdatain(mdat),
        .R0(r[0]), .R1(r[1]), .R2(r[2]), .R3(r[3]), .R4(r[4]), .R5(r[5]), .R6(r[6]), .R7(r[7]),
        .R8(r[8]), .R9(r[9]), .R10(r[10]), .R11(r[11]), .R12(r[12]), .R13(r[13]), .R14(r[14]), .R15(r[15]),
        .HI(HI), .LO(LO), .Y(Y), .ZLO(ZLO), .ZHI(ZHI), .Z_register(Z_register)
    );

    typedef struct {
        string name;
        int sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail = 0;

    localparam int S_HI = 16, S_LO = 17, S_Y = 18, S_ZLO = 19, S_ZHI = 20, S_Z = 21;

    function automatic logic [63:0] dut_val(int sel);
        if (sel < 16) return {32'h0, r[sel]};
        case (sel)
            S_HI: return {32'h0, HI};
            S_LO: return {32'h0, LO};
            S_Y: return {32'h0, Y};
            S_ZLO: return {32'h0, ZLO};
            S_ZHI: return {32'h0, ZHI};
            default: return Z_register;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [63:0] act;
            e = sb.pop_front();
            act = dut_val(e.sel);
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [63:0] v);
        sb.push_back('{name, sel, v});
    endtask

    task automatic clear_ctrl();
        clr = 0; rin = '0; rout = '0; op = '0;
        {HIin, Loin, PCin, MDRin, MARin, IRin, Yin, ZHIin, ZLOin, Zin} = '0;
        {HIout, Loout, PCout, MDRout, Yout, Cout, InPortout} = '0;
        {ZHIout, ZHighSelect, ZLOout, ZLowSelect, MDRread, IncPC} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] v);
        mdat = v; MDRread = 1; MDRin = 1; step();
        MDRout = 1; rin[idx] = 1; step();
    endtask

    task automatic alu_op(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv, input logic [2:0] zs);
        load_reg(10, av);
        load_reg(11, bv);
        rout[10] = 1; Yin = 1; step();
        rout[11] = 1; op = o; {ZHIin, ZLOin, Zin} = zs; step();
    endtask

    typedef struct {
        string name;
        logic [4:0] o;
        logic [31:0] av;
        logic [31:0] bv;
        logic [63:0] z;
    } vec_t;

    vec_t vecs[$] = '{
        '{"add",    5'b00000, 32'd5,        32'd7,        64'h0000_0000_0000_000C},
        '{"sub",    5'b00001, 32'd5,        32'd7,        64'h0000_0000_FFFF_FFFE},
        '{"and",    5'b00010, 32'h0000_F0F0, 32'h0000_FF00, 64'h0000_0000_0000_F000},
        '{"or",     5'b00011, 32'h0000_F0F0, 32'h0000_0F0F, 64'h0000_0000_0000_FFFF},
        '{"shr",    5'b00100, 32'h8000_0000, 32'd4,        64'h0000_0000_0800_0000},
        '{"shra",   5'b00101, 32'h8000_0000, 32'h24,       64'h0000_0000_F800_0000},
        '{"shl",    5'b00110, 32'd1,        32'd31,       64'h0000_0000_8000_0000},
        '{"ror",    5'b00111, 32'd1,        32'd1,        64'h0000_0000_8000_0000},
        '{"ror0",   5'b00111, 32'h1234_5678, 32'd0,       64'h0000_0000_1234_5678},
        '{"rol",    5'b01000, 32'h8000_0000, 32'd1,       64'h0000_0000_0000_0001},
        '{"neg",    5'b01001, 32'd9,        32'd5,        64'h0000_0000_FFFF_FFFB},
        '{"not",    5'b01010, 32'd9,        32'd0,        64'h0000_0000_FFFF_FFFF},
        '{"badop",  5'b01011, 32'd7,        32'd7,        64'h0000_0000_0000_0000},
        '{"mul_neg", 5'b01111, 32'd7,       32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB},
        '{"mul",    5'b01111, 32'hFFFF_FFFE, 32'd3,       64'hFFFF_FFFF_FFFF_FFFA}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        clear_ctrl();
        mdat = '0;
        clr = 1; step();
        // arbitrary loads, then a single clr edge must clear everything
        load_reg(5, 32'hA5A5_0001);
        rout[5] = 1; Yin = 1; HIin = 1; Loin = 1; IRin = 1; step();
        alu_op(5'b00000, 32'd1, 32'd2, 3'b001);
        rout[5] = 1; PCin = 1; MDRin = 1; Zin = 1; clr = 1; step();
        for (int i = 0; i < 22; i++) expect_val($sformatf("reset_sel%0d", i), i, 64'h0);

        mdat = 32'd2; MDRread = 1; MDRin = 1; step();
        MDRout = 1; rin[6] = 1; step();
        expect_val("load_r6", 6, 64'd2);
        expect_val("r5_unchanged", 5, 64'd0);
        expect_val("r7_unchanged", 7, 64'd0);

        load_reg(7, 32'd4);
        rout[6] = 1; Yin = 1; step();
        expect_val("y_from_r6", S_Y, 64'd2);
        rout[7] = 1; op = 5'b10000; ZLOin = 1; ZHIin = 1; step();
        expect_val("div2_4_q", S_ZLO, 64'd0);
        expect_val("div2_4_r", S_ZHI, 64'd2);
        ZLOout = 1; Loin = 1; step();
        expect_val("lo_from_zlo", S_LO, 64'd0);
        ZHIout = 1; HIin = 1; step();
        expect_val("hi_from_zhi", S_HI, 64'd2);

        alu_op(5'b10000, 32'd18, 32'd4, 3'b001);
        expect_val("div18_4_q", S_ZLO, 64'd4);
        expect_val("div18_4_r", S_ZHI, 64'd2);
        alu_op(5'b10000, 32'hFFFF_FFF9, 32'd2, 3'b001);
        expect_val("divm7_2_q", S_ZLO, 64'hFFFF_FFFD);
        expect_val("divm7_2_r", S_ZHI, 64'hFFFF_FFFF);
        alu_op(5'b10000, 32'hFFFF_FFF9, 32'd0, 3'b001);
        expect_val("div0_q", S_ZLO, 64'd0);
        expect_val("div0_r", S_ZHI, 64'hFFFF_FFF9);

        foreach (vecs[k]) begin
            alu_op(vecs[k].o, vecs[k].av, vecs[k].bv, 3'b001);
            expect_val(vecs[k].name, S_Z, vecs[k].z);
        end
        alu_op(5'b00000, 32'd1, 32'd2, 3'b010);
        expect_val("zlo_only", S_Z, 64'hFFFF_FFFF_0000_0003);
        alu_op(5'b00001, 32'd5, 32'd7, 3'b100);
        expect_val("zhi_only", S_Z, 64'h0000_0000_0000_0003);

        load_reg(1, 32'd11);
        load_reg(2, 32'd22);
        rout[1] = 1; rout[2] = 1; rin[3] = 1; step();
        expect_val("prio_r1_r2", 3, 64'd11);
        load_reg(0, 32'hAA);
        load_reg(15, 32'hF);
        rout[0] = 1; rout[15] = 1; rin[14] = 1; step();
        expect_val("prio_r0_r15", 14, 64'hAA);
        HIout = 1; Yout = 1; rin[9] = 1; step();
        expect_val("prio_hi_y", 9, 64'd2);
        rin[9] = 1; step();
        expect_val("no_strobe", 9, 64'd0);
        load_reg(12, 32'd55);
        InPortout = 1; rin[12] = 1; step();
        expect_val("inport_off", 12, 64'd0);

        mdat = 32'hFFFF_FFFF; MDRread = 1; MDRin = 1; step();
        MDRout = 1; PCin = 1; step();
        IncPC = 1; step();
        PCout = 1; rin[4] = 1; step();
        expect_val("pc_wrap", 4, 64'd0);
        MDRout = 1; PCin = 1; IncPC = 1; step();
        PCout = 1; rin[4] = 1; step();
        expect_val("pcin_prio", 4, 64'hFFFF_FFFF);

        mdat = 32'h0004_0001; MDRread = 1; MDRin = 1; step();
        MDRout = 1; IRin = 1; step();
        Cout = 1; rin[8] = 1; step();
        expect_val("cout_neg", 8, 64'hFFFC_0001);
        mdat = 32'hFFF3_FFFF; MDRread = 1; MDRin = 1; step();
        MDRout = 1; IRin = 1; step();
        Cout = 1; rin[8] = 1; step();
        expect_val("cout_pos", 8, 64'h0003_FFFF);

        step();
        step();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
